uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side FIFO read port and status flags of uart_rx.
// The slave modport is the receiver; the master modport is its consumer.
interface uart_rx_if;
    logic       rdreq_i;
    logic [7:0] data_o;
    logic       empty_o;
    logic       full_o;
    logic       busy_o;
    logic       frame_err_o;
    logic       overrun_o;

    modport master (
        output rdreq_i,
        input  data_o, empty_o, full_o, busy_o, frame_err_o, overrun_o
    );

    modport slave (
        input  rdreq_i,
        output data_o, empty_o, full_o, busy_o, frame_err_o, overrun_o
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a centre-sampling FSM feeding a show-ahead receive FIFO.
// Frame errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx #(
    parameter int unsigned ClkPerBit = 16,
    parameter int unsigned AddrWidth = 3
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      RXD,
    uart_rx_if.slave  bus
);
    localparam int unsigned CntWidth = $clog2(ClkPerBit);
    localparam int unsigned Depth    = 1 << AddrWidth;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(ClkPerBit - 1);
    localparam logic [CntWidth-1:0] CntHalf = CntWidth'(ClkPerBit / 2 - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic                rxd_meta, rxd_sync, rxd_prev;
    state_e              state_q;
    logic [CntWidth-1:0] cnt_clk;
    logic [2:0]          bit_idx;
    logic [7:0]          shift_q;
    logic                frame_err_q, overrun_q;

    logic [7:0]          mem [Depth];
    logic [AddrWidth:0]  wr_ptr, rd_ptr;
    logic                empty, full, push, pop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_clk     <= '0;
            bit_idx     <= '0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rxd_prev && !rxd_sync) begin
                        state_q <= StStart;
                        cnt_clk <= '0;
                    end
                end
                StStart: begin
                    // Mid-start-bit check; a high line here was only a glitch.
                    if (cnt_clk == CntHalf) begin
                        cnt_clk <= '0;
                        bit_idx <= '0;
                        state_q <= rxd_sync ? StIdle : StData;
                    end else begin
                        cnt_clk <= cnt_clk + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_clk == CntLast) begin
                        cnt_clk <= '0;
                        shift_q <= {rxd_sync, shift_q[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_clk <= cnt_clk + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_clk == CntLast) begin
                        cnt_clk <= '0;
                        state_q <= StIdle;
                        if (!rxd_sync) begin
                            frame_err_q <= 1'b1;
                        end else if (full) begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_clk <= cnt_clk + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Space is judged before any same-edge pop, so a pop never makes room for this push.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]) &&
                (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]);
        push  = (state_q == StStop) && (cnt_clk == CntLast) && rxd_sync && !full;
        pop   = bus.rdreq_i && !empty;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AddrWidth-1:0]] <= shift_q;
        end
    end

    assign bus.data_o      = empty ? 8'h00 : mem[rd_ptr[AddrWidth-1:0]];
    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    assign bus.busy_o      = (state_q != StIdle);
    assign bus.frame_err_o = frame_err_q;
    assign bus.overrun_o   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit, expected
// bytes and flag pulses are tracked by a queue-based model and compared on read.
module tb_uart_rx;
    localparam int unsigned ClkPerBit = 16;
    localparam int unsigned Depth     = 8;

    logic clk = 1'b0;
    logic rstn;
    logic rxd;

    uart_rx_if u_if ();

    uart_rx #(
        .ClkPerBit (ClkPerBit),
        .AddrWidth (3)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .RXD  (rxd),
        .bus  (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;

    int   cyc        = 0;
    int   fall_cyc   = 0;
    int   ferr_seen  = 0;
    int   ovr_seen   = 0;
    logic empty_prev = 1'b1;

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        empty_prev <= u_if.empty_o;
        if (empty_prev === 1'b1 && u_if.empty_o === 1'b0) fall_cyc <= cyc + 1;
        if (u_if.frame_err_o === 1'b1) ferr_seen <= ferr_seen + 1;
        if (u_if.overrun_o === 1'b1) ovr_seen <= ovr_seen + 1;
    end

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         exp_empty;
        int         exp_ferr_inc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_head(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got a read with model queue empty, expected a queued byte", name);
        end else begin
            e = exp_q.pop_front();
            check(name, u_if.data_o, e);
            check("head_not_empty", u_if.empty_o, 0);
        end
    endtask

    task automatic read_byte(input string name);
        check_head(name);
        u_if.rdreq_i = 1'b1;
        @(negedge clk);
        u_if.rdreq_i = 1'b0;
    endtask

    // Called on a negedge. With pop set, rdreq_i is raised for exactly the stop-sample edge,
    // which is 155 edges after the start edge (2 sync + 1 detect + 8 + 8*16 + 16).
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit pop,
                              input bit hold_low);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        if (!stop) exp_ferr++;
        else if (exp_q.size() >= Depth) exp_ovr++;
        else exp_q.push_back(d);
        fork
            for (int i = 0; i < 10; i++) begin
                rxd = bits[i];
                repeat (ClkPerBit) @(negedge clk);
            end
            if (pop) begin
                repeat (154) @(negedge clk);
                check_head("pop_at_push_head");
                u_if.rdreq_i = 1'b1;
                @(negedge clk);
                u_if.rdreq_i = 1'b0;
                check("pop_at_push_not_empty", u_if.empty_o, 0);
            end
        join
        rxd = hold_low ? 1'b0 : 1'b1;
        idle(4);
    endtask

    initial begin
        int         start_cyc;
        int         f0;
        int         o0;
        logic [7:0] partial;

        vecs[0] = '{8'h3C, 1'b0, 1'b1, 1};
        vecs[1] = '{8'h5A, 1'b1, 1'b0, 0};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 0};

        rstn         = 1'b0;
        rxd          = 1'b1;
        u_if.rdreq_i = 1'b0;
        idle(3);
        rstn = 1'b1;
        idle(1);
        check("rst_data", u_if.data_o, 8'h00);
        check("rst_empty", u_if.empty_o, 1);
        check("rst_full", u_if.full_o, 0);
        check("rst_busy", u_if.busy_o, 0);
        check("rst_ferr", u_if.frame_err_o, 0);
        check("rst_ovr", u_if.overrun_o, 0);

        // Basic frame and latency from the start edge
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check("a5_latency", (fall_cyc > start_cyc) && (fall_cyc - start_cyc <= 164), 1);
        read_byte("a5_data");
        check("a5_empty_after_pop", u_if.empty_o, 1);

        // Short low glitch is rejected at the start-bit midpoint
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(1);
        check("glitch_busy_seen", u_if.busy_o, 1);
        idle(6);
        check("glitch_busy_cleared", u_if.busy_o, 0);
        idle(10);
        check("glitch_empty", u_if.empty_o, 1);
        check("glitch_ferr", ferr_seen, exp_ferr);
        check("glitch_ovr", ovr_seen, exp_ovr);

        for (int i = 0; i < 6; i++) begin
            f0 = ferr_seen;
            send_frame(vecs[i].data, vecs[i].stop, 1'b0, 1'b0);
            check("vec_ferr_pulses", ferr_seen - f0, vecs[i].exp_ferr_inc);
            check("vec_empty", u_if.empty_o, vecs[i].exp_empty);
            if (!vecs[i].exp_empty) read_byte("vec_data");
        end

        // Frame error with the line left low: no retrigger until it returns high
        f0 = ferr_seen;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        idle(30);
        check("hold_low_busy", u_if.busy_o, 0);
        check("hold_low_ferr", ferr_seen - f0, 1);
        rxd = 1'b1;
        idle(20);
        check("hold_low_release_busy", u_if.busy_o, 0);
        check("hold_low_empty", u_if.empty_o, 1);

        // Fill to full, then overrun on the ninth byte
        for (int i = 0; i < 9; i++) begin
            o0 = ovr_seen;
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
            if (i == 6) check("fill7_not_full", u_if.full_o, 0);
            if (i == 7) check("fill8_full", u_if.full_o, 1);
            if (i == 8) begin
                check("ninth_overrun", ovr_seen - o0, 1);
                check("ninth_still_full", u_if.full_o, 1);
            end
        end
        for (int i = 0; i < 8; i++) read_byte("drain_data");
        check("drain_empty", u_if.empty_o, 1);

        // Full FIFO: a pop on the push edge does not make room for that push
        for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
        o0 = ovr_seen;
        send_frame(8'h18, 1'b1, 1'b1, 1'b0);
        check("full_pop_push_overrun", ovr_seen - o0, 1);
        check("full_pop_push_not_full", u_if.full_o, 0);
        for (int i = 0; i < 7; i++) read_byte("drain2_data");
        check("drain2_empty", u_if.empty_o, 1);

        // One stored byte, pop coinciding with a push of 0x55
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        check("pop_push_count_one", u_if.empty_o, 0);
        read_byte("pop_push_data");
        check("pop_push_final_empty", u_if.empty_o, 1);

        // Reset during bit 4 of a frame, with a byte already stored
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        check("pre_reset_stored", u_if.empty_o, 0);
        partial = 8'h12;
        rxd = 1'b0;
        idle(ClkPerBit);
        for (int i = 0; i < 4; i++) begin
            rxd = partial[i];
            idle(ClkPerBit);
        end
        rxd = partial[4];
        idle(8);
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        rxd  = 1'b1;
        exp_q.delete();
        idle(1);
        check("mid_rst_data", u_if.data_o, 8'h00);
        check("mid_rst_empty", u_if.empty_o, 1);
        check("mid_rst_full", u_if.full_o, 0);
        check("mid_rst_busy", u_if.busy_o, 0);
        idle(20);
        check("mid_rst_no_ferr", ferr_seen, exp_ferr);
        check("mid_rst_no_ovr", ovr_seen, exp_ovr);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        read_byte("post_rst_data");
        check("post_rst_empty", u_if.empty_o, 1);

        check("total_ferr", ferr_seen, exp_ferr);
        check("total_ovr", ovr_seen, exp_ovr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
